// File: rtl/systolic_result_drain_if.sv
// rtl/systolic_result_drain_if.sv - result element stream from the drain toward result memory
interface systolic_result_drain_if #(
    parameter int OUT_W = 32,
    parameter int IDX_W = 4
) ();
    logic             rd_valid;
    logic             rd_ready;
    logic [OUT_W-1:0] rd_data;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_last;
    logic             rd_sat;

    modport master (
        output rd_valid, rd_data, rd_idx, rd_last, rd_sat,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_data, rd_idx, rd_last, rd_sat,
        output rd_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - snapshots systolic accumulators on done and streams them out
module systolic_result_drain #(
    parameter int DATA_W = 32,
    parameter int DIM    = 3,
    parameter int OUT_W  = 32,
    parameter int IDX_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [DIM*DIM*DATA_W-1:0]  c_flat,
    input  logic                       ovf_clr,
    systolic_result_drain_if.master    rd,
    output logic                       acc_clr,
    output logic                       busy,
    output logic                       overrun
);
    localparam int NUM = DIM * DIM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         snap [NUM];
    logic [IDX_W-1:0]          idx;
    logic [OUT_W-1:0]          data_q;
    logic                      last_q;
    logic                      sat_q;

    logic                      xfer;
    logic                      at_last;
    logic                      capture;
    logic [IDX_W-1:0]          nxt_idx;
    logic signed [DATA_W-1:0]  src;
    logic [OUT_W-1:0]          src_data;
    logic                      src_sat;

    assign xfer    = (state == DRAIN) && rd.rd_ready;
    assign at_last = (idx == LAST_IDX);
    // A new tile is accepted when idle, or exactly on the final handshake so tiles abut.
    assign capture = done_in && ((state == IDLE) || (xfer && at_last));
    assign nxt_idx = at_last ? '0 : idx + 1'b1;

    // Element to present after this edge: first element of the incoming tile, or the next snapshot.
    assign src = capture ? c_flat[DATA_W-1:0] : snap[nxt_idx];

    generate
        if (OUT_W < DATA_W) begin : g_sat
            localparam logic signed [DATA_W-1:0] MAXV = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [DATA_W-1:0] MINV = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                src_sat  = 1'b1;
                src_data = MAXV[OUT_W-1:0];
                if (src > MAXV) begin
                    src_data = MAXV[OUT_W-1:0];
                end else if (src < MINV) begin
                    src_data = MINV[OUT_W-1:0];
                end else begin
                    src_sat  = 1'b0;
                    src_data = src[OUT_W-1:0];
                end
            end
        end else if (OUT_W == DATA_W) begin : g_pass
            assign src_data = src;
            assign src_sat  = 1'b0;
        end else begin : g_sext
            assign src_data = {{(OUT_W-DATA_W){src[DATA_W-1]}}, src};
            assign src_sat  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            acc_clr <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < NUM; k++) begin
                snap[k] <= '0;
            end
        end else begin
            acc_clr <= capture;

            if (done_in && (state == DRAIN) && !capture) begin
                overrun <= 1'b1;
            end else if (ovf_clr) begin
                overrun <= 1'b0;
            end

            if (capture) begin
                for (int k = 0; k < NUM; k++) begin
                    snap[k] <= c_flat[k*DATA_W +: DATA_W];
                end
                state  <= DRAIN;
                idx    <= '0;
                data_q <= src_data;
                sat_q  <= src_sat;
                last_q <= (NUM == 1);
            end else if (xfer) begin
                if (at_last) begin
                    state  <= IDLE;
                    idx    <= '0;
                    data_q <= '0;
                    sat_q  <= 1'b0;
                    last_q <= 1'b0;
                end else begin
                    idx    <= nxt_idx;
                    data_q <= src_data;
                    sat_q  <= src_sat;
                    last_q <= (nxt_idx == LAST_IDX);
                end
            end
        end
    end

    assign rd.rd_valid = (state == DRAIN);
    assign busy        = (state == DRAIN);
    assign rd.rd_data  = data_q;
    assign rd.rd_idx   = idx;
    assign rd.rd_last  = last_q;
    assign rd.rd_sat   = sat_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - randomized bench with tile-level reference model, 32- and 8-bit builds
module tb_systolic_result_drain;
    localparam int DW = 32;
    localparam int N  = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            done_in = 1'b0;
    logic            rd_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic [N*DW-1:0] c_flat;
    int              c_in [N];

    logic acc_clr32, busy32, ovf32;
    logic acc_clr8, busy8, ovf8;

    int n_cmp = 0;
    int n_err = 0;

    systolic_result_drain_if #(.OUT_W(32), .IDX_W(4)) s32 ();
    systolic_result_drain_if #(.OUT_W(8),  .IDX_W(4)) s8 ();
    assign s32.rd_ready = rd_ready;
    assign s8.rd_ready  = rd_ready;

    systolic_result_drain #(.DATA_W(DW), .DIM(3), .OUT_W(32), .IDX_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .done_in(done_in), .c_flat(c_flat), .ovf_clr(ovf_clr),
        .rd(s32.master), .acc_clr(acc_clr32), .busy(busy32), .overrun(ovf32)
    );

    systolic_result_drain #(.DATA_W(DW), .DIM(3), .OUT_W(8), .IDX_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .done_in(done_in), .c_flat(c_flat), .ovf_clr(ovf_clr),
        .rd(s8.master), .acc_clr(acc_clr8), .busy(busy8), .overrun(ovf8)
    );

    always #5 clk = ~clk;

    always_comb begin
        c_flat = '0;
        for (int k = 0; k < N; k++) c_flat[k*DW +: DW] = c_in[k];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int clamped8(input int v);
        return (v > 127 || v < -128) ? 1 : 0;
    endfunction

    // Tile-level model: a held tile, a read position, and a sticky overrun flag.
    int m_tile [N];
    int m_pos    = 0;
    bit m_active = 1'b0;
    bit m_ovf    = 1'b0;
    bit m_clr    = 1'b0;
    bit m_fin, m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
            m_clr    = 1'b0;
            for (int k = 0; k < N; k++) m_tile[k] = 0;
        end else begin
            m_fin  = m_active && rd_ready && (m_pos == N - 1);
            m_take = done_in && (!m_active || m_fin);
            m_clr  = m_take;
            if (done_in && !m_take) m_ovf = 1'b1;
            else if (ovf_clr)       m_ovf = 1'b0;
            if (m_take) begin
                for (int k = 0; k < N; k++) m_tile[k] = c_in[k];
                m_pos    = 0;
                m_active = 1'b1;
            end else if (m_active && rd_ready) begin
                if (m_pos == N - 1) m_active = 1'b0;
                else                m_pos++;
            end
        end
    end

    always @(posedge clk) begin
        int e;
        #1;
        e = m_active ? m_tile[m_pos] : 0;
        chk("cmp.valid32", s32.rd_valid, m_active);
        chk("cmp.idx32",   s32.rd_idx,   m_active ? m_pos : 0);
        chk("cmp.last32",  s32.rd_last,  m_active && m_pos == N - 1);
        chk("cmp.data32",  $signed(s32.rd_data), e);
        chk("cmp.sat32",   s32.rd_sat,   0);
        chk("cmp.clr32",   acc_clr32,    m_clr);
        chk("cmp.busy32",  busy32,       m_active);
        chk("cmp.ovf32",   ovf32,        m_ovf);
        chk("cmp.valid8",  s8.rd_valid,  m_active);
        chk("cmp.idx8",    s8.rd_idx,    m_active ? m_pos : 0);
        chk("cmp.data8",   $signed(s8.rd_data), m_active ? sat8(e) : 0);
        chk("cmp.sat8",    s8.rd_sat,    m_active ? clamped8(e) : 0);
        chk("cmp.clr8",    acc_clr8,     m_clr);
        chk("cmp.ovf8",    ovf8,         m_ovf);
    end

    int lit_a [N] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    int lit_b [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int lit_s [N] = '{200, -300, 127, -128, 0, 5, -5, 1000, -1000};
    int exp_s [N] = '{127, -128, 127, -128, 0, 5, -5, 127, -128};
    int exp_f [N] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 200)) - 100;
            1: return int'($urandom_range(0, 600)) - 300;
            2: return int'($urandom);
            default: return int'($urandom_range(0, 3)) - 129 + (($urandom_range(0, 1) == 1) ? 256 : 0);
        endcase
    endfunction

    task automatic rnd_c();
        for (int k = 0; k < N; k++) c_in[k] = rnd_val();
    endtask

    // Leaves the bench at the falling edge just after capture, element 0 on the outputs.
    task automatic start_tile(input int v [N]);
        @(negedge clk);
        for (int k = 0; k < N; k++) c_in[k] = v[k];
        done_in  = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    initial begin
        int got, last_c;
        for (int k = 0; k < N; k++) c_in[k] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.valid", s32.rd_valid, 0);
        chk("reset.ovf",   ovf32, 0);

        // Basic tile; c_flat is scrambled during drain to show the snapshot is held.
        start_tile(lit_a);
        for (int k = 0; k < N; k++) begin
            chk("basic.data", $signed(s32.rd_data), lit_a[k]);
            chk("basic.idx",  s32.rd_idx, k);
            chk("basic.last", s32.rd_last, k == N - 1);
            chk("basic.clr",  acc_clr32, k == 0);
            chk("basic.busy", busy32, 1);
            chk("model.basic", m_tile[m_pos], lit_a[k]);
            rnd_c();
            @(negedge clk);
        end
        chk("basic.busy_end",  busy32, 0);
        chk("basic.valid_end", s32.rd_valid, 0);

        // Alternating backpressure.
        start_tile(lit_a);
        got = 0;
        last_c = -1;
        for (int c = 0; c < 40 && got < N; c++) begin
            rd_ready = (c % 2 == 0);
            if (s32.rd_valid && rd_ready) begin
                chk("bp.data", $signed(s32.rd_data), lit_a[got]);
                chk("bp.idx",  s32.rd_idx, got);
                got++;
                last_c = c;
            end
            @(negedge clk);
        end
        rd_ready = 1'b1;
        chk("bp.count",  got, N);
        chk("bp.cycles", last_c + 1, 17);

        // Overrun while draining, then clear, then set-wins-over-clear.
        chk("ovf.pre", ovf32, 0);
        start_tile(lit_a);
        for (int k = 0; k < N; k++) begin
            chk("ovf.data", $signed(s32.rd_data), lit_a[k]);
            if (k == 5) chk("ovf.set", ovf32, 1);
            if (k == 5) chk("model.ovf", m_ovf, 1);
            done_in = (k == 4);
            if (k == 4) rnd_c();
            @(negedge clk);
        end
        done_in = 1'b0;
        chk("ovf.sticky", ovf32, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf.clr", ovf32, 0);
        start_tile(lit_a);
        for (int k = 0; k < N; k++) begin
            done_in = (k == 2) || (k == 3);
            ovf_clr = (k == 3) || (k == 5);
            if (k == 4) chk("ovf.setwins", ovf32, 1);
            if (k == 6) chk("ovf.clr2", ovf32, 0);
            @(negedge clk);
        end
        done_in = 1'b0;
        ovf_clr = 1'b0;

        // Back-to-back tiles.
        start_tile(lit_a);
        repeat (N - 1) @(negedge clk);
        chk("b2b.last", s32.rd_last, 1);
        for (int k = 0; k < N; k++) c_in[k] = lit_b[k];
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("b2b.idx",   s32.rd_idx, 0);
        chk("b2b.data",  $signed(s32.rd_data), 1);
        chk("b2b.clr",   acc_clr32, 1);
        chk("b2b.busy",  busy32, 1);
        chk("b2b.valid", s32.rd_valid, 1);
        chk("model.b2b", m_tile[m_pos], 1);
        repeat (N) @(negedge clk);
        chk("b2b.idle", busy32, 0);

        // Saturation on the 8-bit build, pass-through on the 32-bit build.
        start_tile(lit_s);
        for (int k = 0; k < N; k++) begin
            chk("sat.data8",  $signed(s8.rd_data), exp_s[k]);
            chk("sat.flag8",  s8.rd_sat, exp_f[k]);
            chk("sat.data32", $signed(s32.rd_data), lit_s[k]);
            chk("sat.flag32", s32.rd_sat, 0);
            chk("model.sat",  sat8(m_tile[m_pos]), exp_s[k]);
            @(negedge clk);
        end

        // Reset in the middle of a tile.
        start_tile(lit_a);
        repeat (4) @(negedge clk);
        chk("rst.idx_before", s32.rd_idx, 4);
        rst = 1'b1;
        #1;
        chk("rst.valid", s32.rd_valid, 0);
        chk("rst.data",  s32.rd_data, 0);
        chk("rst.idx",   s32.rd_idx, 0);
        chk("rst.busy",  busy32, 0);
        chk("rst.last",  s32.rd_last, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst.after_valid", s32.rd_valid, 0);
            chk("rst.after_clr",   acc_clr32, 0);
        end

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rnd_c();
            done_in  = ($urandom_range(0, 7) == 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        done_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
